// File: rtl/sprite_pkg.sv
// Shared widths, default frame geometry and scheduler types for the sprite line scheduler.
package sprite_pkg;

   localparam int SPR_IDX_W         = 5;
   localparam int SPR_ATTR_W        = 32;
   localparam int VCOUNT_W          = 10;
   localparam int VISIBLE_LINES_DEF = 480;
   localparam int TOTAL_LINES_DEF   = 525;
   localparam int WR_ENTRY_W        = SPR_IDX_W + SPR_ATTR_W;

   typedef enum logic [1:0] {IDLE, START, WAIT} sched_state_t;

   typedef struct packed {
      logic [SPR_IDX_W-1:0]  idx;
      logic [SPR_ATTR_W-1:0] data;
   } spr_wr_t;

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Scheduler bus: VGA timing and CPU writes in, engine control and attribute writes out.
interface sprite_line_scheduler_if;
   import sprite_pkg::*;

   logic [VCOUNT_W-1:0]   vga_vcount;
   logic                  vga_line_start;
   logic                  cpu_wr_en;
   logic [SPR_IDX_W-1:0]  cpu_wr_idx;
   logic [SPR_ATTR_W-1:0] cpu_wr_data;
   logic                  cpu_wr_ready;
   logic                  spr_wr_en;
   logic [SPR_IDX_W-1:0]  spr_wr_idx;
   logic [SPR_ATTR_W-1:0] spr_wr_data;
   logic                  sprite_start;
   logic [VCOUNT_W-1:0]   eng_vcount;
   logic                  eng_done;
   logic                  line_buf_sel;
   logic                  busy;
   logic [7:0]            overrun_cnt;

   modport master (
      input  vga_vcount, vga_line_start, cpu_wr_en, cpu_wr_idx, cpu_wr_data, eng_done,
      output cpu_wr_ready, spr_wr_en, spr_wr_idx, spr_wr_data, sprite_start,
             eng_vcount, line_buf_sel, busy, overrun_cnt
   );

   modport slave (
      output vga_vcount, vga_line_start, cpu_wr_en, cpu_wr_idx, cpu_wr_data, eng_done,
      input  cpu_wr_ready, spr_wr_en, spr_wr_idx, spr_wr_data, sprite_start,
             eng_vcount, line_buf_sel, busy, overrun_cnt
   );

endinterface

// File: rtl/sprite_wr_fifo.sv
// Synchronous FIFO, combinational head (dout valid whenever !empty); push refused while full
// even if a pop happens in the same cycle.
module sprite_wr_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Starts the sprite engine one cycle after each line pulse for the next visible line and flips the
// ping-pong buffer; queued CPU attribute writes drain one per cycle only in vblank while idle.
module sprite_line_scheduler
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES   = 32,
   parameter int VISIBLE_LINES = VISIBLE_LINES_DEF,
   parameter int TOTAL_LINES   = TOTAL_LINES_DEF,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   sprite_line_scheduler_if.master bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [VCOUNT_W-1:0] LAST_LINE = VCOUNT_W'(TOTAL_LINES - 1);
   localparam logic [VCOUNT_W-1:0] VIS_LINES = VCOUNT_W'(VISIBLE_LINES);
   localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(FIFO_DEPTH);

   if ($clog2(NUM_SPRITES) != SPR_IDX_W) begin : g_idx_w_chk
      $error("NUM_SPRITES does not match SPR_IDX_W");
   end

   sched_state_t        state;
   logic [VCOUNT_W-1:0] tgt;
   logic                tgt_vis;
   logic                push;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   spr_wr_t             fifo_din;
   spr_wr_t             fifo_dout;

   logic                sprite_start_q;
   logic                spr_wr_en_q;
   spr_wr_t             spr_wr_q;
   logic [VCOUNT_W-1:0] eng_vcount_q;
   logic                line_buf_sel_q;
   logic                busy_q;
   logic [7:0]          overrun_q;

   assign tgt      = (bus.vga_vcount == LAST_LINE) ? '0 : bus.vga_vcount + 1'b1;
   assign tgt_vis  = (tgt < VIS_LINES);
   assign fifo_din = {bus.cpu_wr_idx, bus.cpu_wr_data};
   assign push     = bus.cpu_wr_en && !fifo_full;
   // Commits never overlap a render or the cycle a new line could start one.
   assign pop      = (state == IDLE) && (bus.vga_vcount >= VIS_LINES) &&
                     !fifo_empty && !bus.vga_line_start;

   sprite_wr_fifo #(
      .WIDTH (WR_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         sprite_start_q <= 1'b0;
         spr_wr_en_q    <= 1'b0;
         spr_wr_q       <= '0;
         eng_vcount_q   <= '0;
         line_buf_sel_q <= 1'b0;
         busy_q         <= 1'b0;
         overrun_q      <= '0;
      end else begin
         sprite_start_q <= 1'b0;
         spr_wr_en_q    <= pop;
         if (pop) begin
            spr_wr_q <= fifo_dout;
         end
         case (state)
            IDLE: begin
               if (bus.vga_line_start && tgt_vis) begin
                  state          <= START;
                  eng_vcount_q   <= tgt;
                  sprite_start_q <= 1'b1;
                  line_buf_sel_q <= ~line_buf_sel_q;
                  busy_q         <= 1'b1;
               end
            end
            START: begin
               state <= WAIT;
            end
            WAIT: begin
               if (bus.eng_done) begin
                  // A done coinciding with the next pulse chains straight into the next render.
                  if (bus.vga_line_start && tgt_vis) begin
                     state          <= START;
                     eng_vcount_q   <= tgt;
                     sprite_start_q <= 1'b1;
                     line_buf_sel_q <= ~line_buf_sel_q;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else if (bus.vga_line_start && (overrun_q != 8'hFF)) begin
                  overrun_q <= overrun_q + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_wr_ready = (fifo_count != FULL_CNT);
   assign bus.sprite_start = sprite_start_q;
   assign bus.spr_wr_en    = spr_wr_en_q;
   assign bus.spr_wr_idx   = spr_wr_q.idx;
   assign bus.spr_wr_data  = spr_wr_q.data;
   assign bus.eng_vcount   = eng_vcount_q;
   assign bus.line_buf_sel = line_buf_sel_q;
   assign bus.busy         = busy_q;
   assign bus.overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed scenarios plus randomized traffic, every cycle compared against a transaction-level
// model (line budget, write queue, overrun counter) kept in the bench.
module tb_sprite_line_scheduler;
   import sprite_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sprite_line_scheduler_if bus();

   sprite_line_scheduler #(
      .NUM_SPRITES   (32),
      .VISIBLE_LINES (480),
      .TOTAL_LINES   (525),
      .FIFO_DEPTH    (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model: what the scheduler promises, line by line.
   bit          m_rendering;
   bit          m_fresh;
   int          m_line;
   bit          m_sel;
   int          m_ovr;
   logic [36:0] q[$];
   bit          e_start;
   bit          e_wr;
   logic [36:0] e_entry;

   logic [36:0] wr_log[$];
   int          wr_cyc[$];
   logic [36:0] pushed[$];

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_rendering = 0;
      m_fresh     = 0;
      m_line      = 0;
      m_sel       = 0;
      m_ovr       = 0;
      e_start     = 0;
      e_wr        = 0;
      q.delete();
   endtask

   task automatic model_step();
      int tgt;
      bit ls;
      bit room;
      bit go;
      if (!reset) begin
         model_reset();
         return;
      end
      e_start = 0;
      e_wr    = 0;
      go      = 0;
      ls      = bus.vga_line_start;
      tgt     = (int'(bus.vga_vcount) + 1) % 525;
      room    = (q.size() < 8);
      if (!m_rendering && bus.vga_vcount >= 480 && q.size() > 0 && !ls) begin
         e_wr    = 1;
         e_entry = q.pop_front();
      end
      if (bus.cpu_wr_en && room) q.push_back({bus.cpu_wr_idx, bus.cpu_wr_data});
      if (!m_rendering) begin
         go = ls && (tgt < 480);
      end else if (m_fresh) begin
         m_fresh = 0;
      end else if (bus.eng_done) begin
         if (ls && tgt < 480) go = 1;
         else m_rendering = 0;
      end else if (ls) begin
         m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
      end
      if (go) begin
         m_rendering = 1;
         m_fresh     = 1;
         e_start     = 1;
         m_line      = tgt;
         m_sel       = ~m_sel;
      end
   endtask

   task automatic compare_all();
      check_val("sprite_start", bus.sprite_start, e_start);
      check_val("spr_wr_en", bus.spr_wr_en, e_wr);
      if (e_wr) check_val("spr_wr_entry", {bus.spr_wr_idx, bus.spr_wr_data}, e_entry);
      check_val("eng_vcount", bus.eng_vcount, m_line);
      check_val("line_buf_sel", bus.line_buf_sel, m_sel);
      check_val("busy", bus.busy, m_rendering);
      check_val("overrun_cnt", bus.overrun_cnt, m_ovr);
      check_val("cpu_wr_ready", bus.cpu_wr_ready, q.size() < 8);
      if (bus.spr_wr_en) begin
         wr_log.push_back({bus.spr_wr_idx, bus.spr_wr_data});
         wr_cyc.push_back(cyc);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(input int vc);
      bus.vga_vcount     = 10'(vc);
      bus.vga_line_start = 1'b1;
      tick();
      bus.vga_line_start = 1'b0;
   endtask

   task automatic finish_render();
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_start"}, bus.sprite_start, 1'b0);
      check_val({tag, "_wr_en"}, bus.spr_wr_en, 1'b0);
      check_val({tag, "_wr_idx"}, bus.spr_wr_idx, 5'd0);
      check_val({tag, "_wr_data"}, bus.spr_wr_data, 32'd0);
      check_val({tag, "_eng_vcount"}, bus.eng_vcount, 10'd0);
      check_val({tag, "_buf_sel"}, bus.line_buf_sel, 1'b0);
      check_val({tag, "_busy"}, bus.busy, 1'b0);
      check_val({tag, "_overrun"}, bus.overrun_cnt, 8'd0);
      check_val({tag, "_ready"}, bus.cpu_wr_ready, 1'b1);
   endtask

   initial begin
      logic [36:0] ent;
      int          pick;
      bus.vga_vcount     = '0;
      bus.vga_line_start = 1'b0;
      bus.cpu_wr_en      = 1'b0;
      bus.cpu_wr_idx     = '0;
      bus.cpu_wr_data    = '0;
      bus.eng_done       = 1'b0;
      model_reset();

      // Reset values
      reset = 1'b0;
      idle(2);
      check_reset_outputs("rst");
      reset = 1'b1;
      idle(2);

      // Basic render of line 11, done 50 cycles after the pulse
      pulse(10);
      check_val("l11_start", bus.sprite_start, 1'b1);
      check_val("l11_vcount", bus.eng_vcount, 10'd11);
      check_val("l11_sel", bus.line_buf_sel, 1'b1);
      check_val("l11_busy", bus.busy, 1'b1);
      idle(49);
      finish_render();
      check_val("l11_busy_done", bus.busy, 1'b0);

      // Wrap from the last line, then an invisible target
      pulse(524);
      check_val("wrap_start", bus.sprite_start, 1'b1);
      check_val("wrap_vcount", bus.eng_vcount, 10'd0);
      idle(5);
      finish_render();
      pulse(479);
      check_val("l480_no_start", bus.sprite_start, 1'b0);
      check_val("l480_not_busy", bus.busy, 1'b0);
      idle(2);

      // Nine pushes during a visible line: eight fit, none commit
      wr_log.delete();
      wr_cyc.delete();
      pushed.delete();
      bus.vga_vcount = 10'd100;
      for (int i = 0; i < 9; i++) begin
         bus.cpu_wr_en   = 1'b1;
         bus.cpu_wr_idx  = (i == 0) ? 5'd5 : (i == 8) ? 5'd8 : 5'($urandom_range(0, 31));
         bus.cpu_wr_data = (i == 0) ? 32'hABCD1234 : (i == 8) ? 32'hDEADBEEF : $urandom;
         check_val("push_ready", bus.cpu_wr_ready, i < 8);
         if (i < 8) pushed.push_back({bus.cpu_wr_idx, bus.cpu_wr_data});
         tick();
      end
      bus.cpu_wr_en = 1'b0;
      check_val("full_ready_low", bus.cpu_wr_ready, 1'b0);
      idle(3);
      check_val("no_commit_visible", wr_log.size(), 0);
      bus.vga_vcount = 10'd480;
      idle(14);
      check_val("drain_count", wr_log.size(), 8);
      if (wr_log.size() == 8) begin
         for (int i = 0; i < 8; i++) check_val("drain_order", wr_log[i], pushed[i]);
         check_val("drain_back_to_back", wr_cyc[7] - wr_cyc[0], 7);
      end
      check_val("drain_first", wr_log.size() > 0 ? wr_log[0] : 37'd0, {5'd5, 32'hABCD1234});

      // Done and pulse together at line 20
      pulse(19);
      idle(3);
      bus.vga_vcount     = 10'd20;
      bus.vga_line_start = 1'b1;
      bus.eng_done       = 1'b1;
      tick();
      bus.vga_line_start = 1'b0;
      bus.eng_done       = 1'b0;
      check_val("chain_start", bus.sprite_start, 1'b1);
      check_val("chain_vcount", bus.eng_vcount, 10'd21);
      check_val("chain_no_overrun", bus.overrun_cnt, 8'd0);
      idle(2);

      // Overrun and saturation
      pulse(30);
      check_val("ovr_first_start", bus.sprite_start, 1'b0);
      check_val("ovr_one", bus.overrun_cnt, 8'd1);
      for (int i = 0; i < 299; i++) begin
         pulse(31 + (i % 400));
         tick();
      end
      check_val("ovr_saturate", bus.overrun_cnt, 8'd255);
      finish_render();

      // Reset mid-render with three queued writes
      pulse(200);
      idle(2);
      bus.vga_vcount = 10'd201;
      for (int i = 0; i < 3; i++) begin
         bus.cpu_wr_en   = 1'b1;
         bus.cpu_wr_idx  = 5'(i);
         bus.cpu_wr_data = $urandom;
         tick();
      end
      bus.cpu_wr_en = 1'b0;
      reset = 1'b0;
      tick();
      check_reset_outputs("midrst");
      reset = 1'b1;
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      check_val("late_done_busy", bus.busy, 1'b0);
      check_val("late_done_start", bus.sprite_start, 1'b0);
      wr_log.delete();
      bus.vga_vcount = 10'd490;
      idle(6);
      check_val("flushed_fifo", wr_log.size(), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         pick = $urandom_range(0, 3);
         if (pick == 0) bus.vga_vcount = 10'($urandom_range(0, 524));
         else if (pick == 1) bus.vga_vcount = 10'($urandom_range(476, 483));
         else if (pick == 2) bus.vga_vcount = 10'($urandom_range(520, 524));
         bus.vga_line_start = ($urandom_range(0, 7) == 0);
         bus.eng_done       = ($urandom_range(0, 5) == 0);
         bus.cpu_wr_en      = ($urandom_range(0, 2) == 0);
         bus.cpu_wr_idx     = 5'($urandom_range(0, 31));
         bus.cpu_wr_data    = $urandom;
         reset              = ($urandom_range(0, 499) != 0);
         tick();
      end
      reset              = 1'b1;
      bus.vga_line_start = 1'b0;
      bus.eng_done       = 1'b0;
      bus.cpu_wr_en      = 1'b0;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Sequences the `sprite_engine` once per scanline and owns its sprite-attribute write port. VGA timing supplies a line pulse; the scheduler then starts the engine to render the *next* visible line into the idle half of a ping-pong line buffer, waits for `done`, and flips buffers. CPU attribute writes are queued in a small FIFO. They are committed to the engine only during vertical blank and only while the engine is idle, so a frame never tears mid-render.

## Interface
Parameters:
- `NUM_SPRITES`, 32: attribute entries; index width is `$clog2(NUM_SPRITES)` (5).
- `VISIBLE_LINES`, 480: rendered lines 0..479.
- `TOTAL_LINES`, 525: lines per frame, including blank.
- `FIFO_DEPTH`, 8: CPU write queue depth (power of two).

Ports:
- `clk` input 1: single system clock.
- `reset` input 1: synchronous, active-low.
- `vga_vcount` input 10: current display line.
- `vga_line_start` input 1: one-cycle pulse at the start of each line.
- `cpu_wr_en` input 1: attribute write request.
- `cpu_wr_idx` input 5: attribute index.
- `cpu_wr_data` input 32: attribute word.
- `cpu_wr_ready` output 1: FIFO not full; a write is accepted only when `cpu_wr_en && cpu_wr_ready`.
- `spr_wr_en` output 1: attribute write strobe to the engine.
- `spr_wr_idx` output 5: attribute index to the engine.
- `spr_wr_data` output 32: attribute word to the engine.
- `sprite_start` output 1: one-cycle render start to the engine.
- `eng_vcount` output 10: line the engine renders; held stable from start until done.
- `eng_done` input 1: engine finished the line.
- `line_buf_sel` output 1: buffer half the engine writes; the display reads `~line_buf_sel`.
- `busy` output 1: state is not IDLE.
- `overrun_cnt` output 8: saturating count of skipped lines.

## Operation
- States: IDLE, START, WAIT.
- Target line: `tgt = (vga_vcount == TOTAL_LINES-1) ? 0 : vga_vcount + 1`.
- IDLE, on `vga_line_start` with `tgt < VISIBLE_LINES`:
  - latch `eng_vcount <= tgt`;
  - go to START.
- IDLE, on `vga_line_start` with `tgt` not visible: remain in IDLE.
- START, exactly one cycle:
  - assert `sprite_start`;
  - toggle `line_buf_sel`;
  - go to WAIT.
- WAIT:
  - `eng_done` → IDLE.
  - `vga_line_start` without `eng_done` → overrun: `overrun_cnt` increments (saturating at 255), the new line is skipped, and the state stays WAIT.
  - `eng_done` and `vga_line_start` in the same cycle → not an overrun; latch the new `tgt` and go straight to START if it is visible, else go to IDLE.
- FIFO push: on `cpu_wr_en && cpu_wr_ready`.
  - `cpu_wr_ready = (count != FIFO_DEPTH)`, computed from the registered count only.
  - When full, a push is refused even if a pop occurs in the same cycle.
- FIFO pop allowed only when all of these hold:
  - state is IDLE;
  - `vga_vcount >= VISIBLE_LINES`;
  - FIFO not empty;
  - `vga_line_start` is low.
- Pop rate: at most one entry per cycle.
- Ordering: FIFO order is preserved; duplicate indices are both written, in order, so the last write wins.
- `eng_done` is ignored in IDLE and START.

## Timing
- Reset values: state IDLE, `sprite_start=0`, `spr_wr_en=0`, `spr_wr_idx=0`, `spr_wr_data=0`, `eng_vcount=0`, `line_buf_sel=0`, `busy=0`, `overrun_cnt=0`, FIFO empty, `cpu_wr_ready=1`.
- A reset mid-render discards the FIFO contents and the render in progress.
- Line pulse at cycle t (IDLE, visible target): `sprite_start` and the `line_buf_sel` toggle both occur at t+1; `busy` is high from t+1.
- Done: `eng_done` at cycle d → IDLE and `busy=0` at d+1.
- FIFO write: a pop at cycle p presents `spr_wr_en/idx/data` registered at p+1, asserted for one cycle.
  - A write popped before a line pulse therefore reaches the engine strictly before that line's `sprite_start`.
- Push-to-output latency: minimum 2 cycles (push at t, pop at t+1, strobe at t+2).
- Maximum engine budget per line: one line period minus 1 cycle.

## Structure
- Package `sprite_pkg` holds:
  - `SPR_IDX_W=5`, `SPR_ATTR_W=32`, `VCOUNT_W=10`;
  - `VISIBLE_LINES` and `TOTAL_LINES` defaults;
  - the state enum `sched_state_t {IDLE, START, WAIT}`.
- Sub-module `sprite_wr_fifo`:
  - synchronous FIFO, 37-bit entries (`{idx, data}`), depth `FIFO_DEPTH`;
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
- The scheduler top contains the FSM, target-line computation, commit gating and output registers.

## Test plan
- Reset, then pulse at `vga_vcount=10`; `eng_done` 50 cycles later → `sprite_start` one cycle after the pulse, `eng_vcount=11`, `line_buf_sel` 0→1, `busy` low one cycle after done.
- Pulse at `vga_vcount=524` → `eng_vcount=0`. Pulse at `vga_vcount=479` → no `sprite_start` (line 480 is not visible).
- 9 pushes during visible line 100 (`idx=5, 0xABCD1234` first, `idx=8, 0xDEADBEEF` last) → `cpu_wr_ready` low after 8 accepted, the 9th is refused and no `spr_wr_en` appears; at `vga_vcount=480` exactly 8 consecutive strobes occur in push order.
- Second pulse while in WAIT with no done → `overrun_cnt=1`, no second `sprite_start`; 300 overruns → `overrun_cnt` saturates at 255.
- `eng_done` and `vga_line_start` in the same cycle at `vga_vcount=20` → `overrun_cnt` unchanged, `sprite_start` next cycle with `eng_vcount=21`.
- Assert `reset` low in WAIT with 3 entries queued → next cycle all outputs at reset values, FIFO empty; a late `eng_done` produces no effect.
